sr_cpu_mc: RTL and testbench



---
 rtl/sr_cpu_mc_pkg.sv | 55 +++++
 rtl/sr_mc_regfile.sv | 35 +++
 rtl/sr_cpu_mc.sv | 227 ++++++++++++++++++++++
 tb/tb_sr_cpu_mc.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_cpu_mc_pkg.sv
// rtl/sr_cpu_mc_pkg.sv - shared types, encodings and immediate helpers for sr_cpu_mc
package sr_cpu_mc_pkg;

   // control states of the multi-cycle core
   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_EXEC  = 2'd1,
      S_HALT  = 2'd2
   } state_t;

   // ALU operations selected by the decoder
   typedef enum logic [2:0] {
      ALU_ADD  = 3'd0,
      ALU_SUB  = 3'd1,
      ALU_AND  = 3'd2,
      ALU_OR   = 3'd3,
      ALU_SLTU = 3'd4,
      ALU_SRL  = 3'd5,
      ALU_PASS = 3'd6
   } alu_op_t;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LUI = 7'b0110111;
   localparam logic [6:0] OP_B   = 7'b1100011;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_SRL  = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_SUB  = 7'b0100000;

   function automatic logic [31:0] immI(input logic [31:0] ir);
      return {{20{ir[31]}}, ir[31:20]};
   endfunction

   function automatic logic [31:0] immB(input logic [31:0] ir);
      return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
   endfunction

   function automatic logic [31:0] immU(input logic [31:0] ir);
      return {ir[31:12], 12'b0};
   endfunction

endpackage

// File: rtl/sr_mc_regfile.sv
// rtl/sr_mc_regfile.sv - register file with two operand ports, one debug port and one write port
module sr_mc_regfile #(
   parameter int NUM_REGS = 32
) (
   input  logic        clk,
   input  logic [4:0]  addr_a,
   output logic [31:0] data_a,
   input  logic [4:0]  addr_b,
   output logic [31:0] data_b,
   input  logic [4:0]  addr_dbg,
   output logic [31:0] data_dbg,
   input  logic        we,
   input  logic [4:0]  wr_addr,
   input  logic [31:0] wr_data
);

   localparam int         AW = (NUM_REGS == 16) ? 4 : 5;
   localparam logic [5:0] NR = 6'(NUM_REGS);

   // no reset on the array: contents are undefined until written
   logic [31:0] regs [NUM_REGS];

   // x0 and addresses beyond the implemented count read as zero
   assign data_a   = (addr_a   == 5'd0 || {1'b0, addr_a}   >= NR) ? 32'd0 : regs[addr_a[AW-1:0]];
   assign data_b   = (addr_b   == 5'd0 || {1'b0, addr_b}   >= NR) ? 32'd0 : regs[addr_b[AW-1:0]];
   assign data_dbg = (addr_dbg == 5'd0 || {1'b0, addr_dbg} >= NR) ? 32'd0 : regs[addr_dbg[AW-1:0]];

   // single write port; x0 is never written
   always_ff @(posedge clk) begin
      if (we && wr_addr != 5'd0 && {1'b0, wr_addr} < NR) begin
         regs[wr_addr[AW-1:0]] <= wr_data;
      end
   end

endmodule

// File: rtl/sr_cpu_mc.sv
// rtl/sr_cpu_mc.sv - multi-cycle schoolRISCV core; SR_CPU_MC_INSTRET_EN adds the instret counter port
module sr_cpu_mc
   import sr_cpu_mc_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          NUM_REGS = 32
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imReq,
   output logic [31:0] imAddr,
   input  logic        imValid,
   input  logic [31:0] imData,
   input  logic [4:0]  regAddr,
   output logic [31:0] regData,
   output logic        halted
`ifdef SR_CPU_MC_INSTRET_EN
   ,
   output logic [31:0] instret
`endif
);

   generate
      if (NUM_REGS != 32 && NUM_REGS != 16) begin : g_bad_num_regs
         $error("sr_cpu_mc: NUM_REGS must be 16 or 32");
      end
      if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
         $error("sr_cpu_mc: RESET_PC must be 4-byte aligned");
      end
   endgenerate

   state_t      state;
   logic [31:0] pc;
   logic [31:0] ir;

   logic [6:0]  opcode;
   logic [6:0]  funct7;
   logic [2:0]  funct3;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;

   logic        legal;
   alu_op_t     alu_op;
   logic        use_imm;
   logic [31:0] imm;
   logic        use_rs1;
   logic        use_rs2;
   logic        writes_rd;
   logic        is_branch;

   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic [31:0] dbg_data;
   logic [31:0] op_b;
   logic [31:0] alu_result;
   logic [31:0] branch_target;
   logic [31:0] next_pc;
   logic        branch_cond;
   logic        take_branch;
   logic        reg_fault;
   logic        fault;
   logic        rf_we;

   assign opcode = ir[6:0];
   assign rd     = ir[11:7];
   assign funct3 = ir[14:12];
   assign rs1    = ir[19:15];
   assign rs2    = ir[24:20];
   assign funct7 = ir[31:25];

   sr_mc_regfile #(.NUM_REGS(NUM_REGS)) u_regfile (
      .clk      (clk),
      .addr_a   (rs1),
      .data_a   (rs1_data),
      .addr_b   (rs2),
      .data_b   (rs2_data),
      .addr_dbg (regAddr),
      .data_dbg (dbg_data),
      .we       (rf_we),
      .wr_addr  (rd),
      .wr_data  (alu_result)
   );

   // decode IR into ALU op, operand sources, register usage and legality
   always_comb begin
      legal     = 1'b0;
      alu_op    = ALU_ADD;
      use_imm   = 1'b0;
      imm       = 32'd0;
      use_rs1   = 1'b0;
      use_rs2   = 1'b0;
      writes_rd = 1'b0;
      is_branch = 1'b0;
      case (opcode)
         OP_R: begin
            use_rs1   = 1'b1;
            use_rs2   = 1'b1;
            writes_rd = 1'b1;
            if (funct7 == F7_BASE) begin
               case (funct3)
                  F3_ADD:  begin legal = 1'b1; alu_op = ALU_ADD;  end
                  F3_AND:  begin legal = 1'b1; alu_op = ALU_AND;  end
                  F3_OR:   begin legal = 1'b1; alu_op = ALU_OR;   end
                  F3_SLTU: begin legal = 1'b1; alu_op = ALU_SLTU; end
                  default: legal = 1'b0;
               endcase
            end else if (funct7 == F7_SUB && funct3 == F3_ADD) begin
               legal  = 1'b1;
               alu_op = ALU_SUB;
            end
         end
         OP_I: begin
            use_rs1   = 1'b1;
            writes_rd = 1'b1;
            use_imm   = 1'b1;
            imm       = immI(ir);
            case (funct3)
               F3_ADD:  begin legal = 1'b1; alu_op = ALU_ADD; end
               F3_OR:   begin legal = 1'b1; alu_op = ALU_OR;  end
               F3_SRL:  begin legal = (funct7 == F7_BASE); alu_op = ALU_SRL; end
               default: legal = 1'b0;
            endcase
         end
         OP_LUI: begin
            legal     = 1'b1;
            writes_rd = 1'b1;
            use_imm   = 1'b1;
            imm       = immU(ir);
            alu_op    = ALU_PASS;
         end
         OP_B: begin
            use_rs1   = 1'b1;
            use_rs2   = 1'b1;
            is_branch = 1'b1;
            legal     = (funct3 != 3'b010) && (funct3 != 3'b011);
         end
         default: legal = 1'b0;
      endcase
   end

   assign op_b = use_imm ? imm : rs2_data;

   // ALU: 32-bit modulo arithmetic, shift amount taken straight from the shamt field
   always_comb begin
      alu_result = 32'd0;
      case (alu_op)
         ALU_ADD:  alu_result = rs1_data + op_b;
         ALU_SUB:  alu_result = rs1_data - op_b;
         ALU_AND:  alu_result = rs1_data & op_b;
         ALU_OR:   alu_result = rs1_data | op_b;
         ALU_SLTU: alu_result = {31'd0, rs1_data < op_b};
         ALU_SRL:  alu_result = rs1_data >> ir[24:20];
         ALU_PASS: alu_result = op_b;
         default:  alu_result = 32'd0;
      endcase
   end

   // branch condition; blt/bge compare signed, bltu/bgeu unsigned
   always_comb begin
      branch_cond = 1'b0;
      case (funct3)
         F3_BEQ:  branch_cond = (rs1_data == rs2_data);
         F3_BNE:  branch_cond = (rs1_data != rs2_data);
         F3_BLT:  branch_cond = ($signed(rs1_data) <  $signed(rs2_data));
         F3_BGE:  branch_cond = ($signed(rs1_data) >= $signed(rs2_data));
         F3_BLTU: branch_cond = (rs1_data <  rs2_data);
         F3_BGEU: branch_cond = (rs1_data >= rs2_data);
         default: branch_cond = 1'b0;
      endcase
   end

   // in the 16-register build any used register field with bit4 set is illegal
   assign reg_fault = (NUM_REGS == 16) &&
                      ((use_rs1 && rs1[4]) || (use_rs2 && rs2[4]) || (writes_rd && rd[4]));

   assign branch_target = pc + immB(ir);
   assign take_branch   = is_branch && branch_cond;
   assign fault         = !legal || reg_fault || (take_branch && branch_target[1]);
   assign next_pc       = take_branch ? branch_target : pc + 32'd4;
   assign rf_we         = rst && (state == S_EXEC) && !fault && writes_rd;

   assign imReq   = rst && (state == S_FETCH);
   assign imAddr  = {2'b00, pc[31:2]};
   assign regData = (regAddr == 5'd0) ? pc : dbg_data;

   // control FSM: fetch handshake, one execute cycle, sticky halt on a fault
   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= S_FETCH;
         pc     <= RESET_PC;
         halted <= 1'b0;
      end else begin
         case (state)
            S_FETCH: begin
               if (imValid) begin
                  ir    <= imData;
                  state <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (fault) begin
                  halted <= 1'b1;
                  state  <= S_HALT;
               end else begin
                  pc    <= next_pc;
                  state <= S_FETCH;
               end
            end
            S_HALT:  state <= S_HALT;
            default: state <= S_FETCH;
         endcase
      end
   end

`ifdef SR_CPU_MC_INSTRET_EN
   // count every execute cycle that completes without a fault
   always_ff @(posedge clk) begin
      if (!rst) begin
         instret <= 32'd0;
      end else if (state == S_EXEC && !fault) begin
         instret <= instret + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_sr_cpu_mc.sv
// tb/tb_sr_cpu_mc.sv - self-checking bench for sr_cpu_mc against an instruction-level model
module tb_sr_cpu_mc;

   localparam int N_RAND = 4000;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        imReq;
   logic [31:0] imAddr;
   logic        imValid;
   logic [31:0] imData;
   logic [4:0]  regAddr;
   logic [31:0] regData;
   logic        halted;

   logic        imReq16;
   logic [31:0] imAddr16;
   logic [31:0] imData16;
   logic [4:0]  regAddr16;
   logic [31:0] regData16;
   logic        halted16;
   logic [31:0] prog16 [16];

`ifdef SR_CPU_MC_INSTRET_EN
   logic [31:0] instret;
   logic [31:0] instret16;
`endif

   assign imData16 = prog16[imAddr16[3:0]];

   sr_cpu_mc #(.RESET_PC(32'h0000_0000), .NUM_REGS(32)) dut (
      .clk     (clk),
      .rst     (rst),
      .imReq   (imReq),
      .imAddr  (imAddr),
      .imValid (imValid),
      .imData  (imData),
      .regAddr (regAddr),
      .regData (regData),
      .halted  (halted)
`ifdef SR_CPU_MC_INSTRET_EN
      ,
      .instret (instret)
`endif
   );

   sr_cpu_mc #(.RESET_PC(32'h0000_0000), .NUM_REGS(16)) dut16 (
      .clk     (clk),
      .rst     (rst),
      .imReq   (imReq16),
      .imAddr  (imAddr16),
      .imValid (1'b1),
      .imData  (imData16),
      .regAddr (regAddr16),
      .regData (regData16),
      .halted  (halted16)
`ifdef SR_CPU_MC_INSTRET_EN
      ,
      .instret (instret16)
`endif
   );

   int          checks = 0;
   int          errors = 0;
   int          stall_left = 0;
   bit          rand_wait = 1'b0;
   logic [31:0] imem [64];

   // instruction-level model: phase 0 = waiting for a word, 1 = word held, 2 = halted
   int          m_phase = 0;
   logic [31:0] m_pc = 32'd0;
   logic [31:0] m_ir = 32'd0;
   logic        m_halt = 1'b0;
   logic [31:0] m_instret = 32'd0;
   logic [31:0] m_reg [32];
   bit          m_known [32];

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
      return {imm, rs1, f3, rd, 7'h13};
   endfunction

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'h33};
   endfunction

   function automatic logic [31:0] enc_b(input logic [12:0] off, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'h63};
   endfunction

   function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd);
      return {imm, rd, 7'h37};
   endfunction

   function automatic logic [31:0] gen_rand();
      int          k;
      int          o;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  bf3 [6];
      k   = int'($urandom_range(0, 99));
      rd  = 5'($urandom_range(0, 7));
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      bf3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
      o   = int'($urandom_range(0, 16)) - 8;
      if (k < 25) begin
         case ($urandom_range(0, 4))
            0:       return enc_r(7'h00, rs2, rs1, 3'd0, rd);
            1:       return enc_r(7'h20, rs2, rs1, 3'd0, rd);
            2:       return enc_r(7'h00, rs2, rs1, 3'd7, rd);
            3:       return enc_r(7'h00, rs2, rs1, 3'd6, rd);
            default: return enc_r(7'h00, rs2, rs1, 3'd3, rd);
         endcase
      end else if (k < 50) begin
         case ($urandom_range(0, 2))
            0:       return enc_i(12'($urandom), rs1, 3'd0, rd);
            1:       return enc_i(12'($urandom), rs1, 3'd6, rd);
            default: return enc_i({7'h00, 5'($urandom)}, rs1, 3'd5, rd);
         endcase
      end else if (k < 58) begin
         return enc_u(20'($urandom), rd);
      end else if (k < 88) begin
         return enc_b(13'(o * 4), rs2, rs1, bf3[$urandom_range(0, 5)]);
      end else if (k < 94) begin
         return enc_b(13'(o * 4 + 2), rs2, rs1, bf3[$urandom_range(0, 5)]);
      end else begin
         case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return enc_r(7'h01, rs2, rs1, 3'd0, rd);
            2:       return enc_i(12'($urandom), rs1, 3'd1, rd);
            3:       return enc_b(13'd8, rs2, rs1, 3'd2);
            4:       return enc_i({7'h20, 5'd3}, rs1, 3'd5, rd);
            default: return {12'($urandom), rs1, 3'd2, rd, 7'h03};
         endcase
      end
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
      end
   endtask

   // execute one instruction word according to the ISA rules
   task automatic model_exec();
      logic [6:0]  opc;
      logic [6:0]  f7;
      logic [2:0]  f3;
      int          rd;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [31:0] immi;
      logic [31:0] tgt;
      logic [12:0] off;
      bit          ok;
      bit          wr;
      bit          tk;
      opc  = m_ir[6:0];
      f3   = m_ir[14:12];
      f7   = m_ir[31:25];
      rd   = int'(m_ir[11:7]);
      a    = (m_ir[19:15] == 5'd0) ? 32'd0 : m_reg[m_ir[19:15]];
      b    = (m_ir[24:20] == 5'd0) ? 32'd0 : m_reg[m_ir[24:20]];
      immi = {{20{m_ir[31]}}, m_ir[31:20]};
      ok   = 1'b1;
      wr   = 1'b0;
      tk   = 1'b0;
      res  = 32'd0;
      case (opc)
         7'h33: begin
            wr = 1'b1;
            if      (f7 == 7'h00 && f3 == 3'd0) res = a + b;
            else if (f7 == 7'h20 && f3 == 3'd0) res = a - b;
            else if (f7 == 7'h00 && f3 == 3'd7) res = a & b;
            else if (f7 == 7'h00 && f3 == 3'd6) res = a | b;
            else if (f7 == 7'h00 && f3 == 3'd3) res = (a < b) ? 32'd1 : 32'd0;
            else ok = 1'b0;
         end
         7'h13: begin
            wr = 1'b1;
            if      (f3 == 3'd0)                res = a + immi;
            else if (f3 == 3'd6)                res = a | immi;
            else if (f3 == 3'd5 && f7 == 7'h00) res = a >> m_ir[24:20];
            else ok = 1'b0;
         end
         7'h37: begin
            wr  = 1'b1;
            res = m_ir & 32'hFFFF_F000;
         end
         7'h63: begin
            case (f3)
               3'd0:    tk = (a == b);
               3'd1:    tk = (a != b);
               3'd4:    tk = ($signed(a) <  $signed(b));
               3'd5:    tk = ($signed(a) >= $signed(b));
               3'd6:    tk = (a <  b);
               3'd7:    tk = (a >= b);
               default: ok = 1'b0;
            endcase
         end
         default: ok = 1'b0;
      endcase
      off = {m_ir[31], m_ir[7], m_ir[30:25], m_ir[11:8], 1'b0};
      tgt = m_pc + {{19{off[12]}}, off};
      if (ok && tk && tgt[1]) ok = 1'b0;
      if (!ok) begin
         m_phase = 2;
         m_halt  = 1'b1;
      end else begin
         if (wr && rd != 0) begin
            m_reg[rd]   = res;
            m_known[rd] = 1'b1;
         end
         m_pc      = tk ? tgt : m_pc + 32'd4;
         m_instret = m_instret + 32'd1;
         m_phase   = 0;
      end
   endtask

   task automatic model_step();
      if (!rst) begin
         m_pc      = 32'd0;
         m_phase   = 0;
         m_halt    = 1'b0;
         m_instret = 32'd0;
      end else if (m_phase == 0) begin
         if (imValid) begin
            m_ir    = imem[m_pc[7:2]];
            m_phase = 1;
         end
      end else if (m_phase == 1) begin
         model_exec();
      end
   endtask

   task automatic compare();
      check("imReq", 32'(imReq), 32'(rst && m_phase == 0));
      check("imAddr", imAddr, m_pc >> 2);
      check("halted", 32'(halted), 32'(m_halt));
      if (regAddr == 5'd0) check("regData_pc", regData, m_pc);
      else if (m_known[regAddr]) check("regData_x", regData, m_reg[regAddr]);
`ifdef SR_CPU_MC_INSTRET_EN
      check("instret", instret, m_instret);
`endif
   endtask

   task automatic drive();
      if (stall_left > 0) begin
         imValid = 1'b0;
         stall_left--;
      end else if (rand_wait) begin
         imValid = ($urandom_range(0, 2) != 0);
      end else begin
         imValid = 1'b1;
      end
      imData = imem[imAddr[5:0]];
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
      drive();
   endtask

   task automatic peek(input logic [4:0] a, input logic [31:0] exp, input string name);
      regAddr = a;
      #1;
      check(name, regData, exp);
   endtask

   task automatic peek16(input logic [4:0] a, input logic [31:0] exp, input string name);
      regAddr16 = a;
      #1;
      check(name, regData16, exp);
   endtask

   initial begin
      int halt_cnt;
      rst       = 1'b0;
      imValid   = 1'b0;
      imData    = 32'd0;
      regAddr   = 5'd0;
      regAddr16 = 5'd0;
      for (int i = 0; i < 32; i++) begin
         m_reg[i]   = 32'd0;
         m_known[i] = 1'b0;
      end
      for (int i = 0; i < 64; i++) imem[i] = 32'd0;
      for (int i = 0; i < 16; i++) prog16[i] = 32'd0;

      imem[0]  = enc_i(12'd5,     5'd0, 3'd0, 5'd1);
      imem[1]  = enc_i(12'hFF9,   5'd1, 3'd0, 5'd2);
      imem[2]  = enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3);
      imem[3]  = enc_i(12'hFFF,   5'd0, 3'd0, 5'd1);
      imem[4]  = enc_i(12'd1,     5'd0, 3'd0, 5'd2);
      imem[5]  = enc_b(13'd8, 5'd2, 5'd1, 3'd4);
      imem[6]  = 32'h0000_0000;
      imem[7]  = enc_b(13'd8, 5'd2, 5'd1, 3'd6);
      imem[8]  = enc_b(13'd8, 5'd2, 5'd1, 3'd5);
      imem[9]  = enc_b(13'd8, 5'd2, 5'd1, 3'd7);
      imem[10] = 32'h0000_0000;
      imem[11] = 32'h0000_0000;

      prog16[0] = enc_i(12'd9, 5'd0, 3'd0, 5'd0);
      prog16[1] = enc_i(12'd2, 5'd0, 3'd0, 5'd6);
      prog16[2] = enc_r(7'h00, 5'd0, 5'd6, 3'd0, 5'd7);
      prog16[3] = enc_i(12'd1, 5'd0, 3'd0, 5'd16);

      // reset state
      tick();
      tick();
      check("rst_imReq", 32'(imReq), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      peek(5'd0, 32'd0, "rst_pc");

      // zero-wait three-instruction run
      rst = 1'b1;
      repeat (6) tick();
      peek(5'd1, 32'd5, "t1_x1");
      peek(5'd2, 32'hFFFF_FFFE, "t1_x2");
      peek(5'd3, 32'd7, "t1_x3");
      peek(5'd0, 32'd12, "t1_pc");
      check("model_x3", m_reg[3], 32'd7);

      // 16-register core: x0 stays zero, x16 is illegal
      repeat (2) tick();
      check("e_halted", 32'(halted16), 32'd1);
      check("e_imReq", 32'(imReq16), 32'd0);
      peek16(5'd0, 32'd12, "e_pc");
      peek16(5'd6, 32'd2, "e_x6");
      peek16(5'd7, 32'd2, "e_x7");

      // five-cycle stall on the second fetch
      rst = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      stall_left = 5;
      repeat (5) tick();
      peek(5'd0, 32'd4, "stall_pc_held");
      repeat (5) tick();
      peek(5'd0, 32'd12, "stall_pc");
      peek(5'd3, 32'd7, "stall_x3");

      // branch direction with x1=-1, x2=1
      repeat (6) tick();
      peek(5'd0, 32'd28, "blt_taken");
      repeat (2) tick();
      peek(5'd0, 32'd32, "bltu_not_taken");
      repeat (2) tick();
      peek(5'd0, 32'd36, "bge_not_taken");
      repeat (2) tick();
      peek(5'd0, 32'd44, "bgeu_taken");
      repeat (2) tick();
      peek(5'd0, 32'd44, "illegal_pc");
      check("illegal_halted", 32'(halted), 32'd1);
      repeat (4) tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      peek(5'd0, 32'd0, "halt_exit_pc");
      check("halt_exit_halted", 32'(halted), 32'd0);

      // reset during fetch while imValid is high
      tick();
      tick();
      rst     = 1'b0;
      imValid = 1'b1;
      tick();
      rst = 1'b1;
      peek(5'd0, 32'd0, "rst_fetch_pc");
`ifdef SR_CPU_MC_INSTRET_EN
      check("rst_fetch_instret", instret, 32'd0);
`endif
      repeat (6) tick();
      peek(5'd0, 32'd12, "rst_fetch_pc3");
`ifdef SR_CPU_MC_INSTRET_EN
      check("instret_3", instret, 32'd3);
`endif

      // randomized programs with random fetch latency and resets
      for (int i = 1; i < 8; i++) imem[i-1] = enc_i(12'($urandom), 5'd0, 3'd0, 5'(i));
      for (int i = 7; i < 64; i++) imem[i] = gen_rand();
      rand_wait = 1'b1;
      rst = 1'b0;
      tick();
      rst = 1'b1;
      halt_cnt = 0;
      for (int c = 0; c < N_RAND; c++) begin
         regAddr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
         if (m_halt) halt_cnt++;
         rst = !((halt_cnt > 3) || ($urandom_range(0, 299) == 0));
         if (!rst) begin
            halt_cnt = 0;
            if ($urandom_range(0, 3) == 0) begin
               for (int i = 7; i < 64; i++) imem[i] = gen_rand();
            end
         end
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
